// File: rtl/alu_pkg.sv
// Shared definitions for the byte-wide add/sub datapath and its sequencers.
// Contents: the byte width, the operation encodings and the sequencer state enum.
package alu_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mp_addsub_seq_if.sv
// Stream and status bundle between an operand source/result sink and mp_addsub_seq.
// Ports (master = source/sink side, slave = sequencer side):
//   abort, in_valid, in_a, in_b, in_op, out_ready  : master -> slave
//   in_ready, out_valid, out_data, out_last, flags : slave -> master
interface mp_addsub_seq_if
  import alu_pkg::*;
();

  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_a;
  logic [BYTE_W-1:0] in_b;
  logic              in_op;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic              out_carry;
  logic              out_negative;
  logic              out_overflow;
  logic              out_zero;

  modport master (
    output abort, in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_last,
           out_carry, out_negative, out_overflow, out_zero
  );

  modport slave (
    input  abort, in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_data, out_last,
           out_carry, out_negative, out_overflow, out_zero
  );

endinterface

// File: rtl/alu_addsub8.sv
// Combinational 8-bit add/subtract slice with carry in and out.
// Ports: a_i, b_i operands; op_i (OP_SUB inverts b); cin_i carry in;
//        sum_o result byte; cout_o carry out; c7_o carry into the top bit.
module alu_addsub8
  import alu_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              op_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o,
  output logic              c7_o
);

  logic [BYTE_W-1:0] summand;
  logic [BYTE_W:0]   total;

  assign summand = (op_i == OP_SUB) ? ~b_i : b_i;
  assign total   = {1'b0, a_i} + {1'b0, summand} + (BYTE_W+1)'(cin_i);
  assign sum_o   = total[BYTE_W-1:0];
  assign cout_o  = total[BYTE_W];
  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of an XOR.
  assign c7_o    = sum_o[BYTE_W-1] ^ a_i[BYTE_W-1] ^ summand[BYTE_W-1];

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: takes NBYTES-wide operands byte-serially
// (LSB first), runs them through alu_addsub8 with chained carry and streams result
// bytes out, with carry/negative/overflow/zero flags on the last byte.
// Ports: clk, rst (async, active high); bus (slave modport of mp_addsub_seq_if).
module mp_addsub_seq
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned CNT_W  = $clog2(NBYTES)
) (
  input  logic          clk,
  input  logic          rst,
  mp_addsub_seq_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_BUSY = 1'(BUSY);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              op_q, op_d;
  logic              zero_q, zero_d;
  logic              out_valid_q, out_valid_d;
  logic [BYTE_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [3:0]        flags_q, flags_d;    // {carry, negative, overflow, zero}

  logic              in_ready_c;
  logic              accept_c;
  logic              cur_op_c;
  logic              cin_c;
  logic              is_last_c;
  logic [BYTE_W-1:0] sum_c;
  logic              cout_c;
  logic              c7_c;
  logic              byte_zero_c;

  // Single output stage: refill whenever the current byte leaves or is absent.
  assign in_ready_c = !bus.abort && (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;

  // Op is taken live on byte 0 and from the latch afterwards.
  assign cur_op_c    = (state_q == ST_IDLE) ? bus.in_op : op_q;
  assign cin_c       = (idx_q == '0) ? cur_op_c : carry_q;
  assign is_last_c   = (state_q == ST_BUSY) && (idx_q == CNT_W'(NBYTES - 1));
  assign byte_zero_c = (sum_c == '0);

  alu_addsub8 u_core (
    .a_i    (bus.in_a),
    .b_i    (bus.in_b),
    .op_i   (cur_op_c),
    .cin_i  (cin_c),
    .sum_o  (sum_c),
    .cout_o (cout_c),
    .c7_o   (c7_c)
  );

  // Next-state and output-register load.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_d        = op_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    flags_d     = flags_q;

    if (bus.abort) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      carry_d     = 1'b0;
      zero_d      = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept_c) begin
        out_valid_d = 1'b1;
        out_data_d  = sum_c;
        out_last_d  = 1'b0;
        flags_d     = 4'b0000;
        carry_d     = cout_c;
        case (state_q)
          ST_IDLE: begin
            op_d    = bus.in_op;
            zero_d  = byte_zero_c;
            idx_d   = CNT_W'(1);
            state_d = ST_BUSY;
          end
          default: begin
            if (is_last_c) begin
              out_last_d = 1'b1;
              flags_d    = {cout_c, sum_c[BYTE_W-1], c7_c ^ cout_c, zero_q & byte_zero_c};
              zero_d     = 1'b1;
              idx_d      = '0;
              state_d    = ST_IDLE;
            end else begin
              zero_d = zero_q & byte_zero_c;
              idx_d  = idx_q + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_q        <= OP_ADD;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_q        <= op_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_carry    = flags_q[3];
  assign bus.out_negative = flags_q[2];
  assign bus.out_overflow = flags_q[1];
  assign bus.out_zero     = flags_q[0];

endmodule

// File: doc/mp_addsub_seq.md
Name: mp_addsub_seq

Overview:
- Multi-precision add/subtract sequencer and initiator for the team's 8-bit add/sub datapath.
- Accepts two NBYTES-wide operands byte-serially, LSB first, on a valid/ready stream.
- Drives the 8-bit add/sub core one byte per cycle and chains carry between bytes.
- Returns result bytes on a valid/ready stream, with final status flags on the last byte.

Parameters:
- NBYTES, 4, bytes per operand (≥2); operand width = 8*NBYTES.
- CNT_W, $clog2(NBYTES), byte index counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous flush; returns the block to IDLE.
- in_valid  in  1  operand byte pair valid.
- in_ready  out  1  block can accept the operand byte pair.
- in_a  in  8  byte of operand A.
- in_b  in  8  byte of operand B.
- in_op  in  1  0 = A+B, 1 = A−B; sampled on byte 0 only.
- out_valid  out  1  result byte valid.
- out_ready  in  1  downstream accepts the result byte.
- out_data  out  8  result byte.
- out_last  out  1  marks the final (MSB) result byte.
- out_carry  out  1  final carry out. For subtract, 1 = no borrow. Valid only with out_last, else 0.
- out_negative  out  1  MSB of the final result. Valid only with out_last, else 0.
- out_overflow  out  1  signed overflow of the full-width operation. Valid only with out_last, else 0.
- out_zero  out  1  all NBYTES result bytes are 0x00. Valid only with out_last, else 0.

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, carry=0, op=0, zero_acc=1. out_valid, out_data, out_last and all flags = 0. in_ready is 1 once rst deasserts.
- Handshake:
  - Input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
  - in_ready = !out_valid | out_ready. This is a single output register and must pass back-to-back bytes at 1 byte/clk.
  - out_* hold stable while out_valid & !out_ready.
- Latency: result byte k is registered in the cycle after input byte k is accepted.
- Core drive (combinational):
  - summand = op ? ~in_b : in_b.
  - cin = (idx==0) ? op : carry.
  - {cout, sum} = in_a + summand + cin.
  - c7 = sum[7] ^ in_a[7] ^ summand[7], i.e. carry into bit 7.
- States:
  - IDLE (idx=0): on accept, latch op=in_op and compute with cin=in_op. Then carry←cout, zero_acc←(sum==0), idx←1, go to BUSY.
  - BUSY: on accept, compute with latched op and cin=carry. Then carry←cout, zero_acc←zero_acc & (sum==0), idx←idx+1.
  - BUSY, final byte (idx==NBYTES−1): on accept, assert out_last=1 with these flags: out_carry=cout, out_negative=sum[7], out_overflow=c7^cout, out_zero=zero_acc & (sum==0). Then idx←0, go to IDLE.
  - in_op changes during BUSY are ignored.
- Output register: loads on every input transfer. out_last and flags load as above; on non-final bytes they load 0. out_valid clears on an output transfer with no simultaneous input transfer.
- Simultaneous events:
  - Output transfer and new input in the same cycle: the new byte loads and out_valid stays 1.
  - abort=1 takes priority over any transfer: state→IDLE, idx=0, carry=0, zero_acc=1, out_valid=0 (the pending result byte is dropped). No input is accepted that cycle (in_ready is forced to 0).
  - rst mid-transaction: same end state as reset; the partial transaction is discarded.
- Next transaction: may start in the cycle after the final byte is accepted; carry is never inherited across transactions.
- Arithmetic: two's complement. Subtract uses the A+~B+1 convention throughout; carry out is the inverted borrow.

Decomposition:
- Shared package alu_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - State enum {IDLE, BUSY}.
  - BYTE_W=8.
- Sub-module alu_addsub8: purely combinational. Inputs a, b, op, cin. Outputs sum, cout, c7. Reused by other multi-byte units.
- The FSM, counter, carry/zero accumulators and output register stay in mp_addsub_seq.

Test Plan (NBYTES=4, bytes listed LSB first):
- Add 0x000000FF+0x00000001, out_ready=1 → out_data 00,01,00,00. out_last on 4th byte only. C=0 N=0 V=0 Z=0. 1-cycle latency per byte.
- Sub 0x00000000−0x00000001 → FF,FF,FF,FF. C=0 (borrow) N=1 V=0 Z=0.
- Add 0x7FFFFFFF+0x00000001 → 00,00,00,80. V=1 N=1 C=0. Sub 0x80000000−0x00000001 → FF,FF,FF,7F, V=1 N=0 C=1.
- Sub 0x12345678−0x12345678 → 00,00,00,00, Z=1 C=1. Then add 0x00000100+0 → Z=0, proving zero_acc and carry reset between transactions.
- Backpressure: out_ready=0 for 5 cycles after byte 1 → in_ready=0, out_data stable. Release → remaining bytes correct, none lost or duplicated. Toggling in_op mid-transaction has no effect.
- abort after 2 bytes of an add with carry pending (A=FF,FF,.. B=01,00,..) → out_valid=0 the next cycle. New add 0x00000001+0x00000001 → 02,00,00,00, not contaminated by the old carry. Repeat with rst asserted asynchronously mid-cycle → all outputs 0 immediately.
